// File: rtl/button_debouncer.sv
// button_debouncer
//   Debounces an already-synchronized push-button level. A level change is
//   accepted only after DEBOUNCE_CYCLES consecutive samples of the new level.
//   Each accepted change raises a single-cycle Press_o or Release_o pulse.
//
//   Optional feature: define BUTTON_DEBOUNCER_LONG_PRESS_EN to enable the
//   long-press detector. When it is enabled, LongPress_o pulses once when the
//   button has been held for LONG_CYCLES cycles, counted from the Press_o
//   cycle. When the macro is undefined, LongPress_o is tied to 0 and no
//   long-press counter is built.
//
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (2..2^24)
//   LONG_CYCLES      hold time for the long-press pulse      (2..2^32)
//
// Ports
//   Clock        in   system clock; all logic runs on its rising edge
//   Reset        in   asynchronous reset, active low
//   Sync_i       in   synchronized button level (1 = pressed)
//   State_o      out  debounced button level
//   Press_o      out  one-cycle pulse on an accepted 0->1 change
//   Release_o    out  one-cycle pulse on an accepted 1->0 change
//   LongPress_o  out  one-cycle pulse when a press reaches LONG_CYCLES
//
// States
//   state        | meaning
//   RELEASED     | debounced level is 0 and the input agrees with it
//   WAIT_PRESS   | debounced level is 0; counting consecutive 1 samples
//   PRESSED      | debounced level is 1 and the input agrees with it
//   WAIT_RELEASE | debounced level is 1; counting consecutive 0 samples

module button_debouncer #(
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter longint unsigned LONG_CYCLES     = 64'd50000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Sync_i,
  output logic State_o,
  output logic Press_o,
  output logic Release_o,
  output logic LongPress_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Out-of-range parameters are rejected when the design is elaborated.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**24) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES < 2 || LONG_CYCLES > 64'h1_0000_0000) begin : g_bad_long
    $error("button_debouncer: LONG_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          level_q,   level_d;
  logic          press_q,   press_d;
  logic          release_q, release_d;

  // The first sample of a new level already counts as 1, so the change is
  // taken on the DEBOUNCE_CYCLES-th consecutive sample. The counter stops at
  // DB_LAST and therefore fits in clog2(DEBOUNCE_CYCLES) bits with no wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (Sync_i) begin
          state_d = WAIT_PRESS;
          cnt_d   = CW'(1);
        end
      end
      WAIT_PRESS: begin
        if (!Sync_i) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!Sync_i) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CW'(1);
        end
      end
      WAIT_RELEASE: begin
        if (Sync_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign State_o   = level_q;
  assign Press_o   = press_q;
  assign Release_o = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt_q,  long_cnt_d;
  logic          long_done_q, long_done_d;
  logic          long_q,      long_d;

  // The count follows the debounced level, not the FSM state. A bounce in
  // WAIT_RELEASE that falls back to PRESSED therefore does not restart it.
  // The counter stops at LONG_LAST, and a done flag blocks any repeat pulse
  // until the level drops to 0.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (!level_q) begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      if (long_cnt_q == LONG_LAST) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        long_cnt_d = long_cnt_q + LW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign LongPress_o = long_q;
`else
  assign LongPress_o = 1'b0;
`endif

endmodule
